// File: rtl/sar_search_pkg.sv
// Shared constants for the sar_search binary-search controller: state encoding,
// comparator result bit positions and a one-hot helper.
package sar_search_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SEARCH = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    localparam int CMP_GT = 2;
    localparam int CMP_EQ = 1;
    localparam int CMP_LT = 0;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/sar_bounds_next.sv
// Combinational window update for one binary-search step: narrows lo/hi from
// the comparator answer, recomputes the midpoint and flags an empty window.
module sar_bounds_next
    import sar_search_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   lo,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] guess,
    input  logic [2:0]       cmp_res,
    output logic [WIDTH:0]   lo_next,
    output logic [WIDTH:0]   hi_next,
    output logic [WIDTH-1:0] guess_next,
    output logic             exhausted
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0]   guess_ext;
    logic [WIDTH+1:0] mid_sum;

    always_comb begin
        guess_ext = {1'b0, guess};
        lo_next   = lo;
        hi_next   = hi;
        exhausted = 1'b0;
        if (cmp_res[CMP_EQ]) begin
            exhausted = 1'b0;
        end else if (cmp_res[CMP_GT]) begin
            lo_next   = guess_ext + ONE;
            exhausted = (guess_ext + ONE) > hi;
        end else if (cmp_res[CMP_LT] || !cmp_res[CMP_GT]) begin
            // LT or all-zero; guess==0 would take hi below zero, so treat it as empty directly
            hi_next   = guess_ext - ONE;
            exhausted = (guess_ext == '0) || (lo > (guess_ext - ONE));
        end
        mid_sum    = {1'b0, lo_next} + {1'b0, hi_next};
        guess_next = WIDTH'(mid_sum >> 1);
    end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search driving comparator input B until EQ.
// Optional macro SAR_SEARCH_ONEHOT_CHECK_EN rejects non-one-hot comparator answers.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [2:0]                   cmp_res,
    output logic [WIDTH-1:0]             guess,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [WIDTH-1:0]             result,
    output logic                         err,
    output logic [$clog2(WIDTH+2)-1:0]   iters
);

    localparam int IW = $clog2(WIDTH+2);
    localparam logic [WIDTH:0]   HI_INIT  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] MID_INIT = WIDTH'(((2**WIDTH) - 1) / 2);

    state_t           state_reg;
    logic [WIDTH:0]   lo_reg;
    logic [WIDTH:0]   hi_reg;
    logic [WIDTH:0]   lo_next;
    logic [WIDTH:0]   hi_next;
    logic [WIDTH-1:0] guess_next;
    logic             exhausted;
    logic             bad_cmp;

    sar_bounds_next #(.WIDTH(WIDTH)) u_bounds (
        .lo         (lo_reg),
        .hi         (hi_reg),
        .guess      (guess),
        .cmp_res    (cmp_res),
        .lo_next    (lo_next),
        .hi_next    (hi_next),
        .guess_next (guess_next),
        .exhausted  (exhausted)
    );

`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
    assign bad_cmp = !is_onehot3(cmp_res);
`else
    assign bad_cmp = 1'b0;
`endif

    assign busy = (state_reg == ST_SEARCH);
    assign done = (state_reg == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            lo_reg    <= '0;
            hi_reg    <= '0;
            guess     <= '0;
            found     <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            iters     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        lo_reg    <= '0;
                        hi_reg    <= HI_INIT;
                        guess     <= MID_INIT;
                        found     <= 1'b0;
                        result    <= '0;
                        err       <= 1'b0;
                        iters     <= '0;
                        state_reg <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    iters <= iters + IW'(1);
                    if (bad_cmp) begin
                        err       <= 1'b1;
                        found     <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (cmp_res[CMP_EQ]) begin
                        result    <= guess;
                        found     <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        lo_reg <= lo_next;
                        hi_reg <= hi_next;
                        guess  <= guess_next;
                        if (exhausted) begin
                            err       <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a behavioural comparator with hidden A,
// directed cases plus random targets checked against a plain binary-search model.
module tb_sar_search;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       cmp_res;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             found;
    logic [WIDTH-1:0] result;
    logic             err;
    logic [2:0]       iters;

    int a_val = 0;
    int mode  = 0;   // 0: honest comparator, 1: always LT, 2: 3'b110 on first sample
    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int got_q[$];
    int exp_found, exp_err, exp_iters, exp_result;

    sar_search #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cmp_res (cmp_res),
        .guess   (guess),
        .busy    (busy),
        .done    (done),
        .found   (found),
        .result  (result),
        .err     (err),
        .iters   (iters)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (mode == 2 && busy && iters == 3'd0) cmp_res = 3'b110;
        else if (mode == 1)                     cmp_res = 3'b001;
        else if (a_val > int'(guess))           cmp_res = 3'b100;
        else if (a_val == int'(guess))          cmp_res = 3'b010;
        else                                    cmp_res = 3'b001;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Integer binary search over [0, 2^WIDTH-1]; a < 0 models a comparator that always answers LT.
    function automatic void model(input int a);
        int lo = 0;
        int hi = (1 << WIDTH) - 1;
        int g;
        exp_q.delete();
        exp_found = 0; exp_err = 0; exp_iters = 0; exp_result = 0;
        while (lo <= hi) begin
            g = (lo + hi) / 2;
            exp_q.push_back(g);
            exp_iters++;
            if (g == a) begin
                exp_found = 1;
                exp_result = g;
                return;
            end
            if (a > g) lo = g + 1;
            else       hi = g - 1;
        end
        exp_err = 1;
    endfunction

    task automatic run(input string tag, input int a, input int md, input bit hold_start, input bit poke_start);
        int cyc;
        a_val = (md == 1) ? -1 : a;
        mode  = md;
        model(a_val);
        if (md == 2) begin
            exp_q.delete();
            exp_q.push_back((1 << (WIDTH - 1)) - 1);
            exp_iters = 1;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
            exp_found = 0; exp_err = 1; exp_result = 0;
`else
            exp_found = 1; exp_err = 0; exp_result = (1 << (WIDTH - 1)) - 1;
`endif
        end
        got_q.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) if (!hold_start) start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy) got_q.push_back(int'(guess));
            if (poke_start) start = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            cyc++;
        end
        if (poke_start) start = 1'b0;
        check({tag, "_done_seen"}, {31'b0, done}, 1);
        check({tag, "_latency"}, cyc, exp_iters + 1);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 0);
        check({tag, "_found"}, {31'b0, found}, exp_found);
        check({tag, "_err"}, {31'b0, err}, exp_err);
        check({tag, "_iters"}, {29'b0, iters}, exp_iters);
        if (exp_found == 1) check({tag, "_result"}, {28'b0, result}, exp_result);
        check({tag, "_nguess"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_guess%0d", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        $display("search %s a=%0d mode=%0d iters=%0d found=%0b err=%0b result=%0d",
                 tag, a, md, iters, found, err, result);
        if (hold_start) begin
            @(negedge clk);
            check({tag, "_idle_after_done"}, {31'b0, busy}, 0);
            @(negedge clk);
            start = 1'b0;
            check({tag, "_restart_busy"}, {31'b0, busy}, 1);
            check({tag, "_restart_guess"}, {28'b0, guess}, (1 << (WIDTH - 1)) - 1);
            cyc = 0;
            while (done !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check({tag, "_restart_done"}, {31'b0, done}, 1);
            @(negedge clk);
        end else begin
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'b0, done}, 0);
            check({tag, "_found_held"}, {31'b0, found}, exp_found);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_guess", {28'b0, guess}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_found", {31'b0, found}, 0);
        check("rst_result", {28'b0, result}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_iters", {29'b0, iters}, 0);
        rst = 1'b0;

        run("a7", 7, 0, 1'b0, 1'b0);
        run("a15", 15, 0, 1'b0, 1'b0);
        run("a0", 0, 0, 1'b0, 1'b0);
        run("always_lt", 0, 1, 1'b0, 1'b0);

        // Abort during the second SEARCH cycle
        a_val = 9;
        mode  = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) rst = 1'b1;
        #1;
        check("abort_guess", {28'b0, guess}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_found", {31'b0, found}, 0);
        check("abort_result", {28'b0, result}, 0);
        check("abort_err", {31'b0, err}, 0);
        check("abort_iters", {29'b0, iters}, 0);
        @(negedge clk) rst = 1'b0;
        run("a9_after_rst", 9, 0, 1'b0, 1'b0);

        run("hold_start", 5, 0, 1'b1, 1'b0);
        run("poke_start", 12, 0, 1'b0, 1'b1);
        run("inject_110", 7, 2, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++)
            run("rand", int'($urandom_range(0, (1 << WIDTH) - 1)), 0, 1'b0, bit'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
